fetch: RTL and testbench

//  Instruction fetch stage directly upstream of decode. Issues in-order 32-bit

---
 rtl/fetch.sv | 150 +++++++++++++++
 tb/tb_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage: in-order memory requests, response FIFO, flush redirect
module fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic [31:0] FLUSH_PC,
  input  logic        STALL,
  input  logic        MEM_WAIT,
  output logic        MEM_REQ_VALID,
  output logic [31:0] MEM_REQ_ADDR,
  input  logic        MEM_REQ_READY,
  input  logic        MEM_RESP_VALID,
  input  logic [31:0] MEM_RESP_DATA,
  output logic [31:0] INST_PC,
  output logic [31:0] INST_DATA
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  // Stale responses can pile up across repeated flushes (each flush may add up
  // to DEPTH more), so the discard counter gets one extra bit of headroom.
  localparam int unsigned DW = $clog2(2 * DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_pc_d   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_data_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [DW-1:0] discard_q, discard_d;

  logic [CW:0]   occupancy;
  logic [DW-1:0] pending;
  logic          req_fire;
  logic          resp_take;
  logic          resp_drop;
  logic          push;
  logic          pop;
  logic          has_head;
  logic [31:0]   flush_pc_aligned;

  // Request issue: a slot is reserved in the FIFO for every request in flight,
  // so a returning word can always be pushed.
  always_comb begin
    occupancy     = {1'b0, count_q} + {1'b0, inflight_q};
    MEM_REQ_VALID = !RST && !FLUSH && (32'(occupancy) < DEPTH);
    MEM_REQ_ADDR  = pc_q;
    req_fire      = MEM_REQ_VALID && MEM_REQ_READY;
  end

  // Response classification and pop decision; nothing moves during a flush.
  always_comb begin
    resp_take        = MEM_RESP_VALID && !FLUSH;
    resp_drop        = resp_take && (discard_q != '0);
    push             = resp_take && (discard_q == '0) && (inflight_q != '0);
    has_head         = (count_q != '0);
    pop              = has_head && !STALL && !MEM_WAIT && !FLUSH;
    flush_pc_aligned = FLUSH_PC & 32'hFFFF_FFFC;
  end

  // Head of the FIFO goes straight to decode; an empty FIFO shows a NOP bubble.
  always_comb begin
    INST_PC   = has_head ? fifo_pc_q[rd_ptr_q]   : 32'h0;
    INST_DATA = has_head ? fifo_data_q[rd_ptr_q] : NOP;
  end

  // Next-state: flush redirect, otherwise request/response/pop bookkeeping.
  always_comb begin
    pc_d        = pc_q;
    resp_pc_d   = resp_pc_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_data_d = fifo_data_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    inflight_d  = inflight_q;
    discard_d   = discard_q;
    pending     = discard_q + DW'(inflight_q);

    if (FLUSH) begin
      pc_d       = flush_pc_aligned;
      resp_pc_d  = flush_pc_aligned;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      inflight_d = '0;
      // Everything still outstanding becomes stale; a response landing in the
      // flush cycle itself retires one of those stale entries.
      if (MEM_RESP_VALID && (pending != '0)) begin
        discard_d = pending - 1'b1;
      end else begin
        discard_d = pending;
      end
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (push) begin
        fifo_pc_d[wr_ptr_q]   = resp_pc_q;
        fifo_data_d[wr_ptr_q] = MEM_RESP_DATA;
        wr_ptr_d              = wr_ptr_q + 1'b1;
        resp_pc_d             = resp_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (resp_drop) begin
        discard_d = discard_q - 1'b1;
      end
      inflight_d = inflight_q + CW'(req_fire) - CW'(push);
      count_d    = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers; reset drops all buffered and in-flight bookkeeping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  // FIFO storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge CLK) begin
    fifo_pc_q   <= fifo_pc_d;
    fifo_data_q <= fifo_data_d;
  end

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - self-checking bench for fetch: vector table, directed corners, random vs queue model
module tb_fetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        FLUSH = 1'b0;
  logic [31:0] FLUSH_PC = 32'h0;
  logic        STALL = 1'b0;
  logic        MEM_WAIT = 1'b0;
  logic        MEM_REQ_VALID;
  logic [31:0] MEM_REQ_ADDR;
  logic        MEM_REQ_READY = 1'b0;
  logic        MEM_RESP_VALID = 1'b0;
  logic [31:0] MEM_RESP_DATA = 32'h0;
  logic [31:0] INST_PC;
  logic [31:0] INST_DATA;

  always #5 CLK = ~CLK;

  fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .FLUSH_PC(FLUSH_PC),
    .STALL(STALL), .MEM_WAIT(MEM_WAIT),
    .MEM_REQ_VALID(MEM_REQ_VALID), .MEM_REQ_ADDR(MEM_REQ_ADDR), .MEM_REQ_READY(MEM_REQ_READY),
    .MEM_RESP_VALID(MEM_RESP_VALID), .MEM_RESP_DATA(MEM_RESP_DATA),
    .INST_PC(INST_PC), .INST_DATA(INST_DATA)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Reference model: outstanding requests in order (with stale mark), buffered instructions, next PC.
  typedef struct { logic [31:0] addr; bit stale; } out_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  out_t  out_q[$];
  ent_t  ibuf_q[$];
  mreq_t mem_q[$];
  logic [31:0] mpc = RESET_PC;

  typedef struct {
    bit stall; bit ready; bit rv; logic [31:0] raddr;
    bit ev; logic [31:0] eaddr; bit eempty; logic [31:0] epc;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (!chk_en) return;
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit rst, input bit flush, input logic [31:0] fpc, input bit stall,
                      input bit mw, input bit ready, input int lat, input bit hold);
    bit   rv;
    bit   ev;
    bit   pop;
    int   live;
    out_t o;
    out_t n;
    ent_t e;
    mreq_t m;
    @(negedge CLK);
    rv = !rst && !hold && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    RST = rst; FLUSH = flush; FLUSH_PC = fpc; STALL = stall; MEM_WAIT = mw;
    MEM_REQ_READY = ready; MEM_RESP_VALID = rv;
    MEM_RESP_DATA = rv ? (mem_q[0].addr ^ KEY) : 32'hDEAD_BEEF;
    #1;
    live = 0;
    foreach (out_q[i]) if (!out_q[i].stale) live++;
    ev = !rst && !flush && ((ibuf_q.size() + live) < DEPTH);
    chk("req_valid", 32'(MEM_REQ_VALID), 32'(ev));
    if (ev) chk("req_addr", MEM_REQ_ADDR, mpc);
    if (ibuf_q.size() > 0) begin
      chk("inst_pc", INST_PC, ibuf_q[0].pc);
      chk("inst_data", INST_DATA, ibuf_q[0].data);
    end else begin
      chk("inst_pc", INST_PC, 32'h0);
      chk("inst_data", INST_DATA, NOP);
    end
    if (rst) begin
      out_q.delete(); ibuf_q.delete(); mpc = RESET_PC;
    end else if (flush) begin
      if (rv && out_q.size() > 0) void'(out_q.pop_front());
      foreach (out_q[i]) out_q[i].stale = 1'b1;
      ibuf_q.delete();
      mpc = fpc & 32'hFFFF_FFFC;
    end else begin
      pop = (ibuf_q.size() > 0) && !stall && !mw;
      if (pop) void'(ibuf_q.pop_front());
      if (rv && out_q.size() > 0) begin
        o = out_q.pop_front();
        if (!o.stale) begin
          e.pc = o.addr; e.data = o.addr ^ KEY;
          ibuf_q.push_back(e);
        end
      end
      if (ev && ready) begin
        n.addr = mpc; n.stale = 1'b0;
        out_q.push_back(n);
        mpc = mpc + 32'd4;
      end
    end
    if (rst) begin
      mem_q.delete();
    end else begin
      if (rv) void'(mem_q.pop_front());
      if (MEM_REQ_VALID && ready) begin
        m.addr = MEM_REQ_ADDR; m.due = cyc + lat;
        mem_q.push_back(m);
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    step(1, 0, 32'h0, 0, 0, 0, 1, 0);
    chk_en = 1'b1;
    step(1, 0, 32'h0, 0, 0, 0, 1, 0);
  endtask

  function automatic vec_t mk(input bit stall, input bit ready, input bit rv, input logic [31:0] raddr,
                              input bit ev, input logic [31:0] eaddr, input bit eempty, input logic [31:0] epc);
    vec_t v;
    v.stall = stall; v.ready = ready; v.rv = rv; v.raddr = raddr;
    v.ev = ev; v.eaddr = eaddr; v.eempty = eempty; v.epc = epc;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit stale_seen;
    bit rst_r;
    bit fl_r;
    logic [31:0] fpc_r;

    // Empty FIFO with READY low, then 10 stall cycles with a 1-cycle memory, then drain.
    for (int i = 0; i < 3; i++) vt.push_back(mk(0, 0, 0, 32'h0, 1, 32'h0, 1, 32'h0));
    vt.push_back(mk(1, 1, 0, 32'h0,  1, 32'h0,  1, 32'h0));
    vt.push_back(mk(1, 1, 1, 32'h0,  1, 32'h4,  1, 32'h0));
    vt.push_back(mk(1, 1, 1, 32'h4,  1, 32'h8,  0, 32'h0));
    vt.push_back(mk(1, 1, 1, 32'h8,  1, 32'hC,  0, 32'h0));
    vt.push_back(mk(1, 1, 1, 32'hC,  0, 32'h0,  0, 32'h0));
    for (int i = 0; i < 5; i++) vt.push_back(mk(1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0));
    vt.push_back(mk(0, 1, 0, 32'h0,  0, 32'h0,  0, 32'h0));
    vt.push_back(mk(0, 1, 0, 32'h0,  1, 32'h10, 0, 32'h4));
    vt.push_back(mk(0, 1, 1, 32'h10, 1, 32'h14, 0, 32'h8));
    vt.push_back(mk(0, 1, 1, 32'h14, 1, 32'h18, 0, 32'hC));
    vt.push_back(mk(0, 1, 1, 32'h18, 1, 32'h1C, 0, 32'h10));
    vt.push_back(mk(0, 0, 1, 32'h1C, 1, 32'h20, 0, 32'h14));
    vt.push_back(mk(0, 0, 0, 32'h0,  1, 32'h20, 0, 32'h18));
    vt.push_back(mk(0, 0, 0, 32'h0,  1, 32'h20, 0, 32'h1C));
    vt.push_back(mk(0, 0, 0, 32'h0,  1, 32'h20, 1, 32'h0));

    do_reset();
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge CLK);
      RST = 0; FLUSH = 0; FLUSH_PC = 32'h0; MEM_WAIT = 0;
      STALL = vt[i].stall; MEM_REQ_READY = vt[i].ready;
      MEM_RESP_VALID = vt[i].rv; MEM_RESP_DATA = vt[i].raddr ^ KEY;
      #1;
      chk("tbl_req_valid", 32'(MEM_REQ_VALID), 32'(vt[i].ev));
      if (vt[i].ev) chk("tbl_req_addr", MEM_REQ_ADDR, vt[i].eaddr);
      chk("tbl_inst_pc", INST_PC, vt[i].eempty ? 32'h0 : vt[i].epc);
      chk("tbl_inst_data", INST_DATA, vt[i].eempty ? NOP : (vt[i].epc ^ KEY));
      cyc++;
    end

    // 3-cycle memory, two requests in flight, flush to 0x100.
    do_reset();
    step(0, 0, 32'h0, 0, 0, 1, 3, 0);
    step(0, 0, 32'h0, 0, 0, 1, 3, 0);
    step(0, 1, 32'h100, 0, 0, 0, 3, 0);
    stale_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 32'h0, 0, 0, 1, 3, 0);
      if (INST_DATA !== NOP && (INST_PC == 32'h0 || INST_PC == 32'h4)) stale_seen = 1'b1;
      if (INST_DATA !== NOP) break;
    end
    chk("flush_first_pc", INST_PC, 32'h100);
    chk("flush_first_data", INST_DATA, 32'h100 ^ KEY);
    chk("flush_no_stale", 32'(stale_seen), 32'h0);

    // Unaligned flush target coincident with a response.
    do_reset();
    step(0, 0, 32'h0, 0, 0, 1, 1, 0);
    step(0, 1, 32'h103, 0, 0, 0, 1, 0);
    step(0, 0, 32'h0, 0, 0, 0, 1, 0);
    chk("flush5_req_valid", 32'(MEM_REQ_VALID), 32'h1);
    chk("flush5_req_addr", MEM_REQ_ADDR, 32'h100);
    chk("flush5_dropped", INST_DATA, NOP);
    step(0, 0, 32'h0, 0, 0, 1, 1, 0);
    step(0, 0, 32'h0, 0, 0, 1, 1, 0);
    step(0, 0, 32'h0, 1, 0, 1, 1, 0);
    chk("flush5_head_pc", INST_PC, 32'h100);

    // Reset in the middle of a stream with three buffered instructions.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 1, 0, 1, 1, 0);
    step(1, 0, 32'h0, 1, 0, 1, 1, 0);
    step(0, 0, 32'h0, 1, 0, 0, 1, 0);
    chk("rst_mid_data", INST_DATA, NOP);
    chk("rst_mid_pc", INST_PC, 32'h0);
    chk("rst_mid_req_valid", 32'(MEM_REQ_VALID), 32'h1);
    chk("rst_mid_req_addr", MEM_REQ_ADDR, RESET_PC);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst_r = ($urandom_range(0, 499) == 0);
      fl_r  = ($urandom_range(0, 11) == 0);
      fpc_r = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(rst_r, fl_r, fpc_r,
           $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 9) < 7, int'($urandom_range(1, 3)), $urandom_range(0, 4) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
